// File: rtl/ram_16k.sv
// ----------------------------------------------------------------------------
// ram_16k
//   16K x 16-bit data memory for the Hack CPU data-memory map. It holds the
//   low 16K words of data space.
//
//   Writes are synchronous and reads are combinational. A synchronous reset
//   starts a clear sequencer. The sequencer zeroes one word per cycle and
//   holds busy high until every word has been cleared.
//
// Ports
//   clk      in   1   system clock; all state changes on the rising edge
//   reset    in   1   synchronous, active-high; (re)starts the clear sequence
//   address  in  15   word address; only address[13:0] is decoded
//   in       in  16   write data
//   load     in   1   write enable (ignored while busy or in reset)
//   out      out 16   read data (0x0000 while busy)
//   busy     out  1   high while the clear sequence runs
// ----------------------------------------------------------------------------
module ram_16k #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned ADDR_BITS = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [14:0]      address,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   // The declaration initialisers give the all-zero, not-busy power-up state.
   logic [WIDTH-1:0]     mem [DEPTH] = '{default: '0};
   logic [0:0]           state       = IDLE;
   logic [ADDR_BITS-1:0] clr_cnt     = '0;
   logic [ADDR_BITS-1:0] word;

   // The upper address bit is deliberately not decoded.
   // 0x4000-0x7FFF alias 0x0000-0x3FFF.
   logic [14-ADDR_BITS:0] unused_addr_hi;
   assign unused_addr_hi = address[14:ADDR_BITS];

   assign word = address[ADDR_BITS-1:0];

   // ---------------------------------------------------------------------
   // Clear sequencer
   //   While reset is held, the counter stays at 0.
   //   After reset is released, the sequencer takes one edge per word.
   //   It returns to IDLE on the edge that clears the last word.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == '1)
            state <= IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Single write port
   //   Sources, in priority order: reset (no write), the clearer, the user.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR)
            mem[clr_cnt] <= '0;
         else if (load)
            mem[word] <= in;
      end
   end

   assign busy = (state == CLEAR);

   // While a clear is in progress, out is held at zero.
   // This hides words that have not been cleared yet.
   assign out = busy ? '0 : mem[word];

endmodule

// File: tb/tb_ram_16k.sv
// ----------------------------------------------------------------------------
// tb_ram_16k
//   Randomised self-checking bench for ram_16k. The reference model is a flat
//   word array plus a count of the clear cycles still outstanding.
//   A reset wipes the model at once. This matches the DUT, because out reads
//   zero until the clear finishes and the clear zeroes every word.
// ----------------------------------------------------------------------------
module tb_ram_16k;

   localparam int unsigned DEPTH = 16384;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [14:0] address = '0;
   logic [15:0] in = '0;
   logic        load = 1'b0;
   logic [15:0] out;
   logic        busy;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [15:0] model [DEPTH];
   int unsigned clr_left = 0;

   ram_16k #(.WIDTH(16), .ADDR_BITS(14)) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .in(in),
      .load(load),
      .out(out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle:
   //   1. Drive the inputs after the falling edge.
   //   2. Check the combinational view.
   //   3. Advance the model on the rising edge.
   task automatic step(input logic r, input logic l, input logic [14:0] a, input logic [15:0] d);
      logic [15:0] exp_out;
      @(negedge clk);
      reset = r; load = l; address = a; in = d;
      #1;
      exp_out = (clr_left != 0) ? 16'h0000 : model[a % DEPTH];
      check("out", out, exp_out);
      check("busy", {15'b0, busy}, {15'b0, clr_left != 0});
      @(posedge clk);
      if (r) begin
         clr_left = DEPTH;
         foreach (model[i]) model[i] = 16'h0000;
      end else if (clr_left != 0) begin
         clr_left--;
      end else if (l) begin
         model[a % DEPTH] = d;
      end
   endtask

   task automatic rand_step(input logic r);
      step(r, 1'($urandom), 15'($urandom), 16'($urandom));
   endtask

   initial begin
      foreach (model[i]) model[i] = 16'h0000;

      // Power-up state: not busy, and all words read zero.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 15'($urandom), 16'($urandom));

      // Write sweep of 0x0000..0x0009, then readback with in=0xFFFF.
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 15'(i), 16'(i * 16'h1111));
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, 15'(i), 16'hFFFF);

      // Overwrite word 0. The write step itself checks the old value.
      step(1'b0, 1'b1, 15'h0000, 16'h5555);
      step(1'b0, 1'b0, 15'h0000, 16'h0000);

      // Aliasing: the upper address bit selects the same words.
      step(1'b0, 1'b0, 15'h4000, 16'h0000);
      step(1'b0, 1'b1, 15'h7FFF, 16'hABCD);
      step(1'b0, 1'b0, 15'h3FFF, 16'h0000);
      check("alias_3fff_model", model[16'h3FFF], 16'hABCD);

      // Random traffic, concentrated on a small window to get address hits.
      for (int i = 0; i < 400; i++) begin
         if (i % 2 == 0)
            step(1'b0, 1'($urandom), 15'($urandom_range(0, 31)) | (15'($urandom_range(0, 1)) << 14),
                 16'($urandom));
         else
            rand_step(1'b0);
      end

      // One-cycle reset, then a full clear with random write attempts.
      // The writes are dropped. The run continues past the clear,
      // then reads back the earlier addresses.
      step(1'b1, 1'b0, 15'h0000, 16'h0000);
      for (int i = 0; i < DEPTH + 3; i++)
         rand_step(1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, 15'(i), 16'h0000);
      step(1'b0, 1'b0, 15'h3FFF, 16'h0000);

      // Refill some words, start a clear, and re-assert reset at cycle 100.
      // The clear must then run a full length after the second release.
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b1, 15'(i * 3), 16'($urandom) | 16'h0001);
      step(1'b1, 1'b0, 15'h0000, 16'h0000);
      for (int i = 0; i < 100; i++)
         rand_step(1'b0);
      step(1'b1, 1'b0, 15'h0000, 16'h0000);
      step(1'b1, 1'b1, 15'h0001, 16'hBEEF);  // reset held two cycles
      for (int i = 0; i < DEPTH + 2; i++)
         rand_step(1'b0);

      // Reset with load: reset wins, and no user write occurs.
      step(1'b0, 1'b1, 15'h0005, 16'h7777);
      step(1'b1, 1'b1, 15'h0005, 16'h1234);
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 1'b0, 15'h0005, 16'h0000);
      step(1'b0, 1'b0, 15'h0005, 16'h0000);
      check("reset_with_load_model", model[5], 16'h0000);

      // Normal read and write again after the clear.
      for (int i = 0; i < 40; i++)
         step(1'b0, 1'($urandom), 15'($urandom_range(0, 15)), 16'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
